lsu_ctrl_mo: RTL
================

Name: lsu_ctrl_mo

Overview:
Parametrised multi-outstanding load/store control unit between the AGU and the DTCM. It tracks up to DP in-order outstanding DTCM transactions in an internal tag FIFO. Load responses are aligned and sign- or zero-extended for byte, half and word sizes, then written back to the longpipe wbck port with their itag; store responses retire silently. It replaces the single-outstanding, word-only LSU control stage.

Parameters:
XLEN, 32, data width; must be 32.
AW, 16, DTCM byte-address width.
IW, 1, itag width.
DP, 2, maximum outstanding transactions; must be >= 1 (DP=1 degenerates to single-outstanding).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
agu_cmd_valid  in  1  AGU command valid
agu_cmd_ready  out  1  AGU command accepted
agu_cmd_read  in  1  1=load, 0=store
agu_cmd_addr  in  AW  byte address
agu_cmd_wdata  in  XLEN  store data, pre-lane-aligned
agu_cmd_wmask  in  XLEN/8  store byte mask
agu_cmd_size  in  2  00=byte, 01=half, 10=word
agu_cmd_usign  in  1  1=zero-extend load
agu_cmd_itag  in  IW  instruction tag
dtcm_cmd_valid  out  1  DTCM command valid
dtcm_cmd_ready  in  1  DTCM command ready
dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask  out  1/AW/XLEN/XLEN/8  pass-through of the agu_cmd fields
dtcm_rsp_valid  in  1  DTCM response valid
dtcm_rsp_ready  out  1  LSU accepts response
dtcm_rsp_rdata  in  XLEN  raw word read data
lsu_o_valid  out  1  writeback valid (loads only)
lsu_o_ready  in  1  longpipe wbck ready
lsu_o_wbck_data  out  XLEN  aligned and extended load data
lsu_o_wbck_itag  out  IW  tag of the retiring load
lsu_o_err  out  1  misaligned-access error flag qualified by lsu_o_valid (see Optional Feature)
lsu_idle  out  1  1 when no transaction is outstanding

Behaviour:
- FIFO entry fields: {itag, read, size, usign, addr[1:0], err}. Depth DP, with read/write pointers wrapping at DP and a count of width clog2(DP+1).
- Issue: dtcm_cmd_valid = agu_cmd_valid & ~full. agu_cmd_ready = dtcm_cmd_ready & ~full. Push when agu_cmd_valid & agu_cmd_ready. The command path is combinational, with zero added latency.
- Full: no push, even if a pop happens in the same cycle; the cycle after the pop the block accepts again. This avoids a ready->ready combinational path.
- Response: the head entry is consumed on dtcm_rsp_valid & dtcm_rsp_ready.
  - dtcm_rsp_ready = ~empty & (~head.read | lsu_o_ready).
  - Store responses pop without asserting lsu_o_valid.
- Writeback is combinational from the response:
  - lsu_o_valid = dtcm_rsp_valid & ~empty & head.read.
  - lsu_o_wbck_itag = head.itag.
  - lsu_o_wbck_data and itag are forced to 0 when lsu_o_valid is 0.
- Alignment: shift = head.addr[1:0]*8, data = rdata >> shift.
  - Byte: bit 7 sign-extended, or zero-extended if usign.
  - Half: bit 15 extended likewise.
  - Word: unchanged.
  - Size 11: treated as word.
- Simultaneous push and pop while not full: count unchanged, both pointers advance.
- dtcm_rsp_valid while empty is a protocol violation: rsp_ready=0, no state change. The bench asserts it never occurs.
- Ordering: responses are assumed in command order; the DTCM returns at least 1 cycle after acceptance.
- lsu_idle = empty.
- Reset (async, rst=1): pointers and count = 0, lsu_idle = 1, all FIFO contents don't-care.
  - Outputs during reset: agu_cmd_ready = dtcm_cmd_ready, dtcm_rsp_ready = 0, lsu_o_valid = 0, lsu_o_err = 0.
  - Reset mid-operation drops all outstanding entries; the DTCM is reset concurrently.

Optional Feature:
LSU_MISALIGN_CHK_EN
- Defined: a command is misaligned when (half & addr[0]) | (word & addr[1:0]!=0). A misaligned command is pushed with err=1 but not issued:
  - dtcm_cmd_valid = 0 for that command.
  - agu_cmd_ready = ~full, independent of dtcm_cmd_ready.
- When an err entry reaches the head, it retires without a DTCM response:
  - Load: lsu_o_valid = 1, lsu_o_err = 1, data = 0; pops on lsu_o_ready.
  - Store: pops silently in one cycle.
  - An err head never consumes dtcm_rsp; dtcm_rsp_ready = 0 while it is at the head.
- Undefined: no check; err is always 0, lsu_o_err is tied 0, and misaligned addresses are issued as-is.

Test Plan:
1. Reset, then LW addr 0x10, itag 1, rdata 0xDEADBEEF one cycle later -> lsu_o_valid=1 in the rsp cycle, data 0xDEADBEEF, itag 1, lsu_idle returns to 1.
2. LB addr 0x3, rdata 0x80FF_0000 -> data 0xFFFFFF80. Same with usign=1 -> 0x00000080. LH addr 0x2 -> 0xFFFF80FF.
3. DP=2, three back-to-back commands with DTCM rsp withheld -> third agu_cmd_ready=0 until the first rsp pops. Responses retire in itag order 0,1.
4. Mixed SW then LW with lsu_o_ready=0 for 3 cycles -> store rsp pops immediately; load rsp is held (dtcm_rsp_ready=0), then retires when ready rises.
5. Assert rst with 2 outstanding -> count 0, lsu_o_valid 0 immediately (async). After release, a new LW completes normally.
6. With LSU_MISALIGN_CHK_EN, LW addr 0x2 -> dtcm_cmd_valid=0, lsu_o_valid=1, lsu_o_err=1, data 0. Without the macro -> issued to DTCM, err 0.

Source files
------------

// File: rtl/lsu_ctrl_mo.sv
// rtl/lsu_ctrl_mo.sv - multi-outstanding load/store control between AGU and DTCM
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_ctrl_mo #(
    parameter int XLEN = 32,
    parameter int AW   = 16,
    parameter int IW   = 1,
    parameter int DP   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                agu_cmd_valid,
    output logic                agu_cmd_ready,
    input  logic                agu_cmd_read,
    input  logic [AW-1:0]       agu_cmd_addr,
    input  logic [XLEN-1:0]     agu_cmd_wdata,
    input  logic [XLEN/8-1:0]   agu_cmd_wmask,
    input  logic [1:0]          agu_cmd_size,
    input  logic                agu_cmd_usign,
    input  logic [IW-1:0]       agu_cmd_itag,
    output logic                dtcm_cmd_valid,
    input  logic                dtcm_cmd_ready,
    output logic                dtcm_cmd_read,
    output logic [AW-1:0]       dtcm_cmd_addr,
    output logic [XLEN-1:0]     dtcm_cmd_wdata,
    output logic [XLEN/8-1:0]   dtcm_cmd_wmask,
    input  logic                dtcm_rsp_valid,
    output logic                dtcm_rsp_ready,
    input  logic [XLEN-1:0]     dtcm_rsp_rdata,
    output logic                lsu_o_valid,
    input  logic                lsu_o_ready,
    output logic [XLEN-1:0]     lsu_o_wbck_data,
    output logic [IW-1:0]       lsu_o_wbck_itag,
    output logic                lsu_o_err,
    output logic                lsu_idle
);

    localparam int CW = $clog2(DP + 1);
    localparam int PW = (DP > 1) ? $clog2(DP) : 1;

    typedef struct packed {
        logic [IW-1:0] itag;
        logic          read;
        logic [1:0]    size;
        logic          usign;
        logic [1:0]    addr;
        logic          err;
    } ent_t;

    ent_t            fifo_q [DP];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            full;
    logic            empty;
    logic            cmd_mis;
    logic            push;
    logic            pop;
    logic            err_pop;
    ent_t            head;
    ent_t            new_ent;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] aligned;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DP - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full  = (cnt_q == CW'(DP));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rptr_q];

`ifdef LSU_MISALIGN_CHK_EN
    // size 11 is handled like a word, so it shares the word alignment rule
    assign cmd_mis = ((agu_cmd_size == 2'b01) & agu_cmd_addr[0])
                   | (agu_cmd_size[1] & (agu_cmd_addr[1:0] != 2'b00));
    // trapped commands never reach the DTCM, so they do not wait on its ready
    assign agu_cmd_ready  = ~full & (cmd_mis | dtcm_cmd_ready);
    assign dtcm_cmd_valid = agu_cmd_valid & ~full & ~cmd_mis;
    assign lsu_o_err      = lsu_o_valid & head.err;
`else
    assign cmd_mis        = 1'b0;
    assign agu_cmd_ready  = dtcm_cmd_ready & ~full;
    assign dtcm_cmd_valid = agu_cmd_valid & ~full;
    assign lsu_o_err      = 1'b0;
`endif

    assign dtcm_cmd_read  = agu_cmd_read;
    assign dtcm_cmd_addr  = agu_cmd_addr;
    assign dtcm_cmd_wdata = agu_cmd_wdata;
    assign dtcm_cmd_wmask = agu_cmd_wmask;

    assign push = agu_cmd_valid & agu_cmd_ready;

    always_comb begin
        new_ent       = '0;
        new_ent.itag  = agu_cmd_itag;
        new_ent.read  = agu_cmd_read;
        new_ent.size  = agu_cmd_size;
        new_ent.usign = agu_cmd_usign;
        new_ent.addr  = agu_cmd_addr[1:0];
        new_ent.err   = cmd_mis;
    end

    // an err head retires on its own and must never swallow a DTCM response
    assign dtcm_rsp_ready = ~empty & ~head.err & (~head.read | lsu_o_ready);
    assign err_pop        = ~empty & head.err & (~head.read | lsu_o_ready);
    assign pop            = (dtcm_rsp_valid & dtcm_rsp_ready) | err_pop;
    assign lsu_o_valid    = ~empty & head.read & (head.err | dtcm_rsp_valid);
    assign lsu_idle       = empty;

    assign shifted = dtcm_rsp_rdata >> {head.addr, 3'b000};

    always_comb begin
        aligned = shifted;
        case (head.size)
            2'b00:   aligned = {{(XLEN-8){~head.usign & shifted[7]}}, shifted[7:0]};
            2'b01:   aligned = {{(XLEN-16){~head.usign & shifted[15]}}, shifted[15:0]};
            default: aligned = shifted;
        endcase
    end

    assign lsu_o_wbck_data = (lsu_o_valid & ~head.err) ? aligned : '0;
    assign lsu_o_wbck_itag = lsu_o_valid ? head.itag : '0;

    always_comb begin
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= new_ent;
        end
    end

endmodule
